// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: converts a requested target state into registered J/K
// excitation for a bank of JK flip-flops, then confirms the bank settled by
// comparing its q feedback. It re-drives up to MAX_RETRY times, then flags err.
module jk_excitation_driver #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned TOGGLE_MODE = 0,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err
);

    // Keep the counter at least one bit wide so MAX_RETRY=0 still elaborates.
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCheck,
        StErr
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  target_q;
    logic [RetryW-1:0] retry_q;
    logic [WIDTH-1:0]  j_q;
    logic [WIDTH-1:0]  k_q;
    logic              done_q;
    logic              err_q;

    logic [WIDTH-1:0]  exc_tgt;
    logic [WIDTH-1:0]  diff;
    logic [WIDTH-1:0]  j_exc;
    logic [WIDTH-1:0]  k_exc;

    // Excitation from live q_fb: new request in IDLE, stored target on retry.
    always_comb begin
        exc_tgt = (state_q == StIdle) ? tgt_data : target_q;
        diff    = q_fb ^ exc_tgt;
        if (TOGGLE_MODE != 0) begin
            j_exc = diff;
            k_exc = diff;
        end else begin
            j_exc = diff & exc_tgt;
            k_exc = diff & q_fb;
        end
    end

    // Control FSM with registered j/k/done/err; pulses default low every cycle.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            target_q <= '0;
            retry_q  <= '0;
            j_q      <= '0;
            k_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            j_q    <= '0;
            k_q    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tgt_valid) begin
                        target_q <= tgt_data;
                        j_q      <= j_exc;
                        k_q      <= k_exc;
                        retry_q  <= '0;
                        state_q  <= StDrive;
                    end
                end
                StDrive: begin
                    state_q <= StCheck;
                end
                StCheck: begin
                    if (q_fb == target_q) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (retry_q < RetryMax) begin
                        retry_q <= retry_q + RetryW'(1);
                        j_q     <= j_exc;
                        k_q     <= k_exc;
                        state_q <= StDrive;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= StErr;
                    end
                end
                StErr: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tgt_ready = (state_q == StIdle);
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench: two drivers (set/reset and toggle mode) share one request
// stream, each driving its own behavioural JK bank. A stuck flag freezes both banks.
module tb_jk_excitation_driver;

    localparam int W  = 4;
    localparam int MR = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tgt_valid;
    logic [W-1:0] tgt_data;
    logic         stuck;
    logic         rdy0, rdy1, done0, done1, err0, err1;
    logic [W-1:0] j0, k0, j1, k1;
    logic [W-1:0] q0 = '0;
    logic [W-1:0] q1 = '0;

    always #5 clk = ~clk;

    jk_excitation_driver #(.WIDTH(W), .TOGGLE_MODE(0), .MAX_RETRY(MR)) dut0 (
        .CLK(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
        .tgt_ready(rdy0), .q_fb(q0), .j(j0), .k(k0), .done(done0), .err(err0)
    );

    jk_excitation_driver #(.WIDTH(W), .TOGGLE_MODE(1), .MAX_RETRY(MR)) dut1 (
        .CLK(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
        .tgt_ready(rdy1), .q_fb(q1), .j(j1), .k(k1), .done(done1), .err(err1)
    );

    // Behavioural JK flip-flop: 00 hold, 01 reset, 10 set, 11 toggle.
    function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] jv,
                                             input logic [W-1:0] kv);
        logic [W-1:0] n;
        for (int i = 0; i < W; i++) begin
            if (jv[i] && kv[i])       n[i] = ~q[i];
            else if (jv[i])           n[i] = 1'b1;
            else if (kv[i])           n[i] = 1'b0;
            else                      n[i] = q[i];
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!stuck) begin
            q0 <= jk_next(q0, j0, k0);
            q1 <= jk_next(q1, j1, k1);
        end
    end

    // Reference excitation table: which inputs move bit q to bit t.
    task automatic excite(input logic [W-1:0] q, input logic [W-1:0] t, input bit tog,
                          output logic [W-1:0] jv, output logic [W-1:0] kv);
        for (int i = 0; i < W; i++) begin
            jv[i] = 1'b0;
            kv[i] = 1'b0;
            if (q[i] != t[i]) begin
                if (tog) begin
                    jv[i] = 1'b1;
                    kv[i] = 1'b1;
                end else if (t[i]) begin
                    jv[i] = 1'b1;
                end else begin
                    kv[i] = 1'b1;
                end
            end
        end
    endtask

    typedef struct {
        logic [W-1:0] j0, k0, j1, k1;
        int           nd;
        bit           is_err;
        logic [W-1:0] final_q;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] mq       = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Issue one request. keep=1 leaves tgt_valid high for a back-to-back follow-up.
    task automatic send(input logic [W-1:0] t, input bit stk, input bit keep);
        int   n;
        exp_t e;
        if (!tgt_valid) begin
            n = 0;
            @(negedge clk);
            while (!rdy0 && n < 60) begin
                @(negedge clk);
                n++;
            end
            stuck = stk;
        end
        tgt_data  = t;
        tgt_valid = 1'b1;
        n = 0;
        forever begin
            @(posedge clk);
            if (rst_n && rdy0) break;
            n++;
            if (n > 60) begin
                chk("accept_timeout", 32'd0, 32'd1);
                tgt_valid = 1'b0;
                return;
            end
        end
        excite(mq, t, 1'b0, e.j0, e.k0);
        excite(mq, t, 1'b1, e.j1, e.k1);
        if (stuck && mq != t) begin
            e.nd = MR + 1;
            e.is_err = 1'b1;
            e.final_q = mq;
        end else begin
            e.nd = 1;
            e.is_err = 1'b0;
            e.final_q = t;
        end
        mq = e.final_q;
        sb.push_back(e);
        @(negedge clk);
        if (!keep) tgt_valid = 1'b0;
    endtask

    // Monitor: on each accept, pop the expected transaction and check every cycle of it.
    initial begin
        exp_t         e;
        int           len;
        bit           drv;
        logic [W-1:0] ej0, ek0, ej1, ek1;
        bit           edone, eerr, erdy;
        forever begin
            @(posedge clk);
            if (rst_n && tgt_valid && rdy0) begin
                @(negedge clk);
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 32'd0, 32'd1);
                    continue;
                end
                e   = sb.pop_front();
                len = 2 * e.nd + 1;
                for (int c = 1; c <= len; c++) begin
                    if (c > 1) @(negedge clk);
                    if (!rst_n) break;
                    drv   = (c % 2 == 1) && (c < len);
                    ej0   = drv ? e.j0 : '0;
                    ek0   = drv ? e.k0 : '0;
                    ej1   = drv ? e.j1 : '0;
                    ek1   = drv ? e.k1 : '0;
                    edone = (c == len) && !e.is_err;
                    eerr  = (c == len) && e.is_err;
                    erdy  = (c == len) && !e.is_err;
                    chk($sformatf("setrst {j,k,done,err,rdy} cyc%0d", c),
                        32'({j0, k0, done0, err0, rdy0}), 32'({ej0, ek0, edone, eerr, erdy}));
                    chk($sformatf("toggle {j,k,done,err,rdy} cyc%0d", c),
                        32'({j1, k1, done1, err1, rdy1}), 32'({ej1, ek1, edone, eerr, erdy}));
                    if (c == len) begin
                        chk("setrst bank q", 32'(q0), 32'(e.final_q));
                        chk("toggle bank q", 32'(q1), 32'(e.final_q));
                    end
                end
            end
        end
    end

    initial begin
        int  n;
        bit  keep;
        rst_n     = 1'b0;
        tgt_valid = 1'b0;
        tgt_data  = '0;
        stuck     = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset setrst {j,k,done,err,rdy}", 32'({j0, k0, done0, err0, rdy0}), 32'h001);
        chk("reset toggle {j,k,done,err,rdy}", 32'({j1, k1, done1, err1, rdy1}), 32'h001);
        #1 rst_n = 1'b1;

        send(4'b1010, 1'b0, 1'b0);  // from rest
        send(4'b1100, 1'b0, 1'b0);
        send(4'b0110, 1'b0, 1'b0);  // toggle-mode case from 1100
        send(4'b0101, 1'b0, 1'b0);
        send(4'b0101, 1'b0, 1'b0);  // hold target
        send(4'b0000, 1'b0, 1'b0);
        send(4'b1111, 1'b1, 1'b0);  // bank ignores drive -> retries then err
        send(4'b0011, 1'b0, 1'b1);  // back-to-back with valid held high
        send(4'b1100, 1'b0, 1'b0);
        send(4'b0000, 1'b0, 1'b0);

        // Reset in the DRIVE cycle of a 0000 -> 1111 request.
        send(4'b1111, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset setrst {j,k,done,err,rdy}", 32'({j0, k0, done0, err0, rdy0}), 32'h001);
        chk("async reset toggle {j,k,done,err,rdy}", 32'({j1, k1, done1, err1, rdy1}), 32'h001);
        mq = 4'b0000;
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post reset quiet", 32'({done0, err0, done1, err1, j0, k0, j1, k1}), 32'd0);
        end
        chk("post reset bank q", 32'(q0), 32'(mq));

        for (int t = 0; t < 40; t++) begin
            keep = ($urandom_range(0, 2) == 0) && (t != 39);
            send(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0), keep);
        end

        n = 0;
        while ((sb.size() != 0 || !rdy0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Drives the J/K inputs of a bank of WIDTH jkff instances so that the bank reaches a requested target state, then verifies the result from the bank's q feedback. It is the controlling side of the JK flip-flop interface: it converts a desired next state into JK excitation values. It sits between a target-state producer (valid/ready handshake) and the flip-flop bank, and retries or flags an error if the bank does not settle.

## Interface
- WIDTH, 4: number of JK flip-flops driven.
- TOGGLE_MODE, 0: 0 means bit changes use set/reset (j=1,k=0 or j=0,k=1). 1 means bit changes use toggle (j=1,k=1).
- MAX_RETRY, 2: number of re-drive attempts after the first mismatch before the driver flags an error.

Ports:
- CLK  input  1  single clock, all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- tgt_valid  input  1  target-state request valid.
- tgt_data  input  WIDTH  requested target state.
- tgt_ready  output  1  driver can accept a target.
- q_fb  input  WIDTH  q outputs of the driven JK bank.
- j  output  WIDTH  registered J drive to the bank.
- k  output  WIDTH  registered K drive to the bank.
- done  output  1  one-cycle pulse: bank matches target.
- err  output  1  one-cycle pulse: retries exhausted without a match.

## Operation
- The FSM has 4 states: IDLE, DRIVE, CHECK, ERR. The reset state is IDLE.
- Outputs on reset: j=0, k=0, done=0, err=0, tgt_ready=1. The stored target and the retry counter are cleared to 0.
- **IDLE:** tgt_ready=1 and j=k=0 (the bank holds).
  - On an edge where tgt_valid and tgt_ready are both high, latch tgt_data as the target.
  - On the same edge, load j/k with the excitation computed from q_fb and tgt_data, clear the retry counter, and go to DRIVE.
- **Excitation per bit i** (q = q_fb[i], t = target[i]):
  - q=t: j=0, k=0.
  - q=0, t=1: j=1, k=0 when TOGGLE_MODE=0; j=1, k=1 when TOGGLE_MODE=1.
  - q=1, t=0: j=0, k=1 when TOGGLE_MODE=0; j=1, k=1 when TOGGLE_MODE=1.
  - j=1,k=1 is never produced for an unchanged bit.
- **DRIVE:** j/k are presented for exactly one cycle. The bank samples them on the next edge. The FSM then goes to CHECK and clears j/k to 0.
- **CHECK:** j=k=0. At the end-of-cycle edge, compare q_fb with the stored target.
  - If they match: done=1 for the next cycle and go to IDLE.
  - If they differ and retry < MAX_RETRY: increment retry, reload j/k from the current q_fb and the stored target, and go to DRIVE.
  - If they differ and retry = MAX_RETRY: go to ERR.
- **ERR:** err=1 and tgt_ready=0 for one cycle, then IDLE.
- The retry counter is $clog2(MAX_RETRY+1) bits wide and never wraps. Retry always recomputes the excitation from the live q_fb, so a toggle-mode retry stays correct even if the bank moved unexpectedly.
- tgt_ready=0 in DRIVE, CHECK and ERR. tgt_valid is ignored in those states; the target stays unchanged and there is no queuing.
- A target equal to the current q still takes the full DRIVE/CHECK path with j=k=0. The latency is identical and there is no shortcut.
- Asserting rst_n low in any state immediately forces j=k=0, done=0, err=0 and state IDLE, without waiting for a clock edge. A pending target is discarded.

## Timing
- Let E0 be the accept edge. j/k are valid in the cycle after E0 (DRIVE).
- At E1 the bank updates and the FSM enters CHECK. At E2 the comparison is made.
- With no retries, done is high in the cycle after E2. Latency from accept edge to done is 2 edges.
- Each retry adds 2 cycles. The worst case is err high in the cycle after edge E(2·(MAX_RETRY+1)).
- done and tgt_ready are both high in the same cycle, so a new target can be accepted on the edge that ends the done pulse.
- j/k, done and err come directly from flops and have no combinational path from inputs.
- q_fb must be stable at each CHECK edge. It is assumed to come from flops on the same CLK.

## Test plan
- Reset, then a target from rest: rst_n=0 then 1, bank q=0000, target 1010, TOGGLE_MODE=0 → in DRIVE j=1010, k=0000; done pulse 2 edges after accept; q=1010; err never asserted.
- Toggle mode: TOGGLE_MODE=1, q=1100, target 0110 → in DRIVE j=1010, k=1010; the bank toggles to 0110; done after 2 edges.
- Hold target: q=0101, target 0101 → j=k=0000 in DRIVE; done after 2 edges; q unchanged.
- Retry then error: the bank ignores j/k (q_fb forced to 0000), target 1111, MAX_RETRY=2 → 3 DRIVE cycles, each with j=1111; err pulse on cycle 6 after accept; done never asserted; tgt_ready returns to 1 the next cycle.
- Busy and back-to-back: tgt_valid held high with 0011 then 1100 → the second target is not accepted until the cycle where done is high; it is accepted on that edge; 2 done pulses in total, with the final q=1100.
- Reset mid-operation: drop rst_n during DRIVE with j=1111 → j=k=0000 and tgt_ready=1 asynchronously; no done or err pulse after release.
